serial_twos_comp_array: RTL and testbench
=========================================

# serial_twos_comp_array

Parametrised, multi-channel, bit-serial two's-complement unit and successor to the single-channel serial inverter. CH independent lanes accept WIDTH-bit words LSB first. Each lane buffers one full word, then re-emits it LSB first in one of four modes: pass, negate, absolute value or saturating negate, with a per-lane overflow flag. It sits between bit-serial producers and consumers in the serial arithmetic datapath.

## Interface
- WIDTH, 8: bits per word; must be ≥ 2.
- CH, 4: number of parallel lanes; must be ≥ 1.
- t_clk  in  1  clock; all state changes on the rising edge.
- r  in  1  reset; synchronous, active-high.
- i_bit  in  CH  one serial input bit per lane, LSB first.
- i_valid  in  1  i_bit is valid this cycle; low means stall, and input state holds.
- i_sof  in  1  qualified by i_valid; marks the LSB of a new word.
- i_mode  in  2  sampled with i_sof: 00 pass, 01 negate, 10 abs, 11 saturating negate.
- o_bit  out  CH  serial result bits, LSB first.
- o_valid  out  1  o_bit valid.
- o_sof  out  1  first (LSB) output beat of a word.
- o_eof  out  1  last (MSB) output beat of a word.
- o_ovf  out  CH  per-lane overflow; valid only while o_eof=1, 0 otherwise.
- o_frame_err  out  1  one-cycle pulse on a framing violation.

## Operation
- Input stage:
  - Bit counter cnt (0..WIDTH-1) and per-lane WIDTH-bit collect registers.
  - A beat is accepted when i_valid=1.
  - Idle state: non-sof beats are ignored; o_frame_err pulses.
  - An accepted i_sof beat stores bit 0, latches i_mode and sets cnt=1.
  - Each following accepted beat stores a bit at index cnt and increments cnt.
  - On the beat with cnt=WIDTH-1, the word is complete. It transfers to the output stage at that edge, and the input stage returns to idle.
  - If i_sof arrives with cnt≠0 mid-word: the partial word is discarded, o_frame_err pulses, and the new word starts with this beat.
- Output stage:
  - Shift register per lane, a bit index, and a per-lane seen_one flag that is cleared on load.
  - Per-lane invert enable inv, computed at load from the buffered word w and the mode:
    - pass: inv=0.
    - negate and sat-negate: inv=1.
    - abs: inv=w[WIDTH-1].
  - Each emitted bit b = w[k]. The lane outputs b XOR (inv AND seen_one), then sets seen_one |= w[k]. This is serial negation: copy bits through the first 1, invert all bits above it.
  - Overflow: ovf = (w == 1 followed by WIDTH-1 zeros) AND mode ∈ {negate, abs, sat-negate}.
  - Saturating negate with ovf=1: the lane emits 0 followed by WIDTH-1 ones (LSB first: ones, then MSB 0), i.e. max positive. o_ovf still asserts.
  - Pass never sets ovf.
  - Emits exactly one beat per cycle once loaded, independent of i_valid.
- Lanes share framing, counter and mode. Only data, inv, seen_one and ovf are per-lane.
- Reset r=1 clears:
  - counters, buffers, seen_one and mode;
  - all outputs to 0 (o_bit, o_valid, o_sof, o_eof, o_ovf, o_frame_err);
  - any in-flight input or output word, which is dropped without an o_eof.
  - After r falls, the first word must begin with i_sof.

## Timing
- MSB of a word accepted on cycle T:
  - o_valid=1 on cycles T+1 … T+WIDTH;
  - o_sof=1 at T+1;
  - o_eof and o_ovf at T+WIDTH.
- Latency from MSB accept to result LSB: 1 cycle. Latency from LSB accept to result LSB: ≥ WIDTH cycles.
- Back-to-back words with i_valid held high produce gap-free output. The next MSB (T+WIDTH) loads on the same edge the previous word's last beat leaves, so no overrun is possible.
- Input stalls stretch only the input stage. If the output stage finishes with no new word loaded, o_valid=0 until the next load.
- o_frame_err is registered and asserts the cycle after the offending beat.
- Reset takes effect at the first rising edge with r=1. Outputs read 0 from the following cycle.

## Test plan
Bench parameters: WIDTH=8, CH=2.

1. **Negate, back-to-back, overflow.** Mode 01, lanes 0x05/0x80, then mode 01 again on the next word with i_valid held high. Required: lane0 0xFB, lane1 0x80 with o_ovf[1]=1 at o_eof; output beats contiguous across both words.
2. **Abs.** Mode 10, lanes 0xFB/0x05. Required: 0x05/0x05, ovf=00. Then lanes 0x80/0x7F. Required: 0x80/0x7F with ovf=01.
3. **Saturating negate.** Mode 11, lanes 0x80/0x01. Required: 0x7F/0xFF, o_ovf=01.
4. **Stalls.** Mode 00, lanes 0xA5/0x3C with i_valid low for 3 cycles after bits 2 and 5. Required: output 0xA5/0x3C, starting exactly 1 cycle after the MSB is accepted, 8 contiguous beats.
5. **Framing error.** i_sof reasserted at bit 4 of a word. Required: o_frame_err pulse; the first word is never emitted; the second word is correct. A non-sof beat while idle also produces a pulse.
6. **Reset mid-word.** r=1 mid-output and mid-input. Required: all outputs 0 the next cycle, no o_eof for the dropped words, and a clean word afterwards.

Source files
------------

// File: rtl/serial_twos_comp_array_if.sv
// Bundle of serial data, framing and status signals between a bit-serial
// producer/consumer pair and the serial two's-complement array.
interface serial_twos_comp_array_if #(
    parameter int CH = 4
);
    logic [CH-1:0] i_bit;
    logic          i_valid;
    logic          i_sof;
    logic [1:0]    i_mode;
    logic [CH-1:0] o_bit;
    logic          o_valid;
    logic          o_sof;
    logic          o_eof;
    logic [CH-1:0] o_ovf;
    logic          o_frame_err;

    modport master (
        output i_bit, i_valid, i_sof, i_mode,
        input  o_bit, o_valid, o_sof, o_eof, o_ovf, o_frame_err
    );

    modport slave (
        input  i_bit, i_valid, i_sof, i_mode,
        output o_bit, o_valid, o_sof, o_eof, o_ovf, o_frame_err
    );
endinterface

// File: rtl/serial_twos_comp_array.sv
// Multi-lane bit-serial two's-complement unit: buffers a full LSB-first word
// per lane, then re-emits it as pass, negate, abs or saturating negate.
module serial_twos_comp_array #(
    parameter int WIDTH = 8,
    parameter int CH    = 4
) (
    input  logic                    t_clk,
    input  logic                    r,
    serial_twos_comp_array_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nx;
    logic   w_start;
    logic   w_store;
    logic   w_load;
    logic   w_frame_err;

    // Input stage: shared counter and mode; the MSB is never buffered, it
    // goes straight from the input pin into the output stage on load.
    logic [CW-1:0]             r_cnt;
    logic [1:0]                r_mode;
    logic [CH-1:0][WIDTH-2:0]  r_buf;

    logic [CH-1:0][WIDTH-1:0]  w_word;
    logic [CH-1:0][WIDTH-1:0]  w_ld_data;
    logic [CH-1:0]             w_ld_inv;
    logic [CH-1:0]             w_ld_ovf;

    // Output stage: bit 0 leaves on the load edge, so only WIDTH-1 bits remain.
    logic [CH-1:0][WIDTH-2:0]  r_sh;
    logic [CH-1:0]             r_inv;
    logic [CH-1:0]             r_seen;
    logic [CH-1:0]             r_ovf;
    logic [CW-1:0]             r_left;

    logic [CH-1:0]             r_obit;
    logic [CH-1:0]             r_oovf;
    logic                      r_ovalid;
    logic                      r_osof;
    logic                      r_oeof;
    logic                      r_ferr;

    // Input framing state register
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Input framing next-state: start, store, load and framing-error decode
    always_comb begin
        w_state_nx  = r_state;
        w_start     = 1'b0;
        w_store     = 1'b0;
        w_load      = 1'b0;
        w_frame_err = 1'b0;
        if (bus.i_valid) begin
            if (bus.i_sof) begin
                w_start     = 1'b1;
                w_frame_err = (r_state == S_COLLECT);
                w_state_nx  = S_COLLECT;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        w_frame_err = 1'b1;
                    end
                    S_COLLECT: begin
                        if (r_cnt == LAST) begin
                            w_load     = 1'b1;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_store = 1'b1;
                        end
                    end
                    default: begin
                        w_state_nx = S_IDLE;
                    end
                endcase
            end
        end else begin
            w_state_nx = r_state;
        end
    end

    // Input collect registers, bit counter and latched mode
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_cnt  <= '0;
            r_mode <= 2'b00;
            r_buf  <= '0;
        end else if (w_start) begin
            r_cnt  <= CW'(1);
            r_mode <= bus.i_mode;
            for (int l = 0; l < CH; l++) begin
                r_buf[l][0] <= bus.i_bit[l];
            end
        end else if (w_store) begin
            r_cnt <= r_cnt + CW'(1);
            for (int l = 0; l < CH; l++) begin
                r_buf[l][r_cnt] <= bus.i_bit[l];
            end
        end else if (w_load) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Per-lane load values: saturation replaces the word by max positive
    always_comb begin
        w_word    = '0;
        w_ld_data = '0;
        w_ld_inv  = '0;
        w_ld_ovf  = '0;
        for (int l = 0; l < CH; l++) begin
            w_word[l]    = {bus.i_bit[l], r_buf[l]};
            w_ld_ovf[l]  = (w_word[l] == MIN_NEG) && (r_mode != 2'b00);
            w_ld_data[l] = w_word[l];
            case (r_mode)
                2'b00: w_ld_inv[l] = 1'b0;
                2'b01: w_ld_inv[l] = 1'b1;
                2'b10: w_ld_inv[l] = w_word[l][WIDTH-1];
                2'b11: begin
                    if (w_ld_ovf[l]) begin
                        w_ld_data[l] = MAX_POS;
                        w_ld_inv[l]  = 1'b0;
                    end else begin
                        w_ld_inv[l]  = 1'b1;
                    end
                end
                default: w_ld_inv[l] = 1'b0;
            endcase
        end
    end

    // Output shifter: invert every bit above the first emitted 1 when inv is set
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_sh     <= '0;
            r_inv    <= '0;
            r_seen   <= '0;
            r_ovf    <= '0;
            r_left   <= '0;
            r_obit   <= '0;
            r_oovf   <= '0;
            r_ovalid <= 1'b0;
            r_osof   <= 1'b0;
            r_oeof   <= 1'b0;
        end else if (w_load) begin
            for (int l = 0; l < CH; l++) begin
                r_sh[l]   <= w_ld_data[l][WIDTH-1:1];
                r_inv[l]  <= w_ld_inv[l];
                r_seen[l] <= w_ld_data[l][0];
                r_ovf[l]  <= w_ld_ovf[l];
                r_obit[l] <= w_ld_data[l][0];
            end
            r_left   <= LAST;
            r_oovf   <= '0;
            r_ovalid <= 1'b1;
            r_osof   <= 1'b1;
            r_oeof   <= 1'b0;
        end else if (r_left != '0) begin
            for (int l = 0; l < CH; l++) begin
                r_obit[l] <= r_sh[l][0] ^ (r_inv[l] & r_seen[l]);
                r_seen[l] <= r_seen[l] | r_sh[l][0];
                r_sh[l]   <= r_sh[l] >> 1;
            end
            r_left   <= r_left - CW'(1);
            r_ovalid <= 1'b1;
            r_osof   <= 1'b0;
            r_oeof   <= (r_left == CW'(1));
            r_oovf   <= (r_left == CW'(1)) ? r_ovf : '0;
        end else begin
            r_obit   <= '0;
            r_oovf   <= '0;
            r_ovalid <= 1'b0;
            r_osof   <= 1'b0;
            r_oeof   <= 1'b0;
        end
    end

    // Framing error pulse, one cycle after the offending beat
    always_ff @(posedge t_clk) begin
        if (r) begin
            r_ferr <= 1'b0;
        end else begin
            r_ferr <= w_frame_err;
        end
    end

    assign bus.o_bit       = r_obit;
    assign bus.o_valid     = r_ovalid;
    assign bus.o_sof       = r_osof;
    assign bus.o_eof       = r_oeof;
    assign bus.o_ovf       = r_oovf;
    assign bus.o_frame_err = r_ferr;
endmodule

// File: tb/tb_serial_twos_comp_array.sv
// Self-checking bench for serial_twos_comp_array: vector table plus framing,
// stall and reset sequences, with a scoreboard of expected output words.
module tb_serial_twos_comp_array;
    localparam int WIDTH = 8;
    localparam int CH    = 2;

    logic t_clk;
    logic r;
    int   cyc;
    int   n_cmp;
    int   n_err;

    serial_twos_comp_array_if #(.CH(CH)) bus ();

    serial_twos_comp_array #(.WIDTH(WIDTH), .CH(CH)) dut (
        .t_clk (t_clk),
        .r     (r),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] e0;
        logic [7:0] e1;
        logic [1:0] ovf;
        int         cyc;
    } sb_t;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] in0;
        logic [7:0] in1;
        logic [7:0] ex0;
        logic [7:0] ex1;
        logic [1:0] ovf;
        bit         stall;
        bit         gap;
    } vec_t;

    sb_t  sb[$];
    int   fe_q[$];
    vec_t tbl[8];

    bit         in_word;
    int         nbeat;
    logic [7:0] col0;
    logic [7:0] col1;

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    always @(posedge t_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic reference: {ovf, result}
    function automatic logic [8:0] model(input logic [1:0] m, input logic [7:0] w);
        logic       mn;
        logic [7:0] neg;
        mn  = (w == 8'h80);
        neg = 8'(-w);
        case (m)
            2'b00:   return {1'b0, w};
            2'b01:   return {mn, neg};
            2'b10:   return {mn, w[7] ? neg : w};
            default: return {mn, mn ? 8'h7F : neg};
        endcase
    endfunction

    // Output monitor: collects each word between o_sof and o_eof
    always @(negedge t_clk) begin
        if (r) begin
            in_word = 1'b0;
        end else begin
            if (in_word) chk("gap", bus.o_valid, 1);
            if (bus.o_valid) begin
                if (bus.o_sof) begin
                    chk("sof_in_word", in_word, 0);
                    in_word = 1'b1;
                    nbeat   = 0;
                    if (sb.size() > 0) chk("sof_cycle", cyc, sb[0].cyc);
                end
                if (in_word && nbeat < 8) begin
                    col0[nbeat] = bus.o_bit[0];
                    col1[nbeat] = bus.o_bit[1];
                end
                nbeat++;
                if (!bus.o_eof) chk("ovf_mid", bus.o_ovf, 0);
                if (bus.o_eof) begin
                    chk("beats", nbeat, 8);
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_eof: got an o_eof, expected none (cycle %0d)", cyc);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        chk("lane0", col0, e.e0);
                        chk("lane1", col1, e.e1);
                        chk("ovf", bus.o_ovf, e.ovf);
                    end
                    in_word = 1'b0;
                end
            end else begin
                chk("idle_flags", {bus.o_sof, bus.o_eof, bus.o_ovf}, 0);
            end
            if (bus.o_frame_err) begin
                n_cmp++;
                if (fe_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_frame_err: got pulse, expected none (cycle %0d)", cyc);
                end else begin
                    chk("frame_err_cycle", cyc, fe_q.pop_front());
                end
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge t_clk);
            bus.i_valid = 1'b0;
            bus.i_sof   = 1'($urandom);
            bus.i_bit   = 2'($urandom);
        end
    endtask

    task automatic send_word(input logic [1:0] m, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] x0, input logic [7:0] x1, input logic [1:0] xo,
                             input bit stall, input bit ferr);
        for (int k = 0; k < 8; k++) begin
            @(negedge t_clk);
            bus.i_valid = 1'b1;
            bus.i_sof   = (k == 0);
            bus.i_mode  = (k == 0) ? m : ~m;
            bus.i_bit   = {w1[k], w0[k]};
            if (k == 0 && ferr) fe_q.push_back(cyc + 1);
            if (k == 7) sb.push_back('{x0, x1, xo, cyc + 1});
            if (stall && (k == 2 || k == 5)) idle(3);
        end
    endtask

    task automatic send_partial(input logic [7:0] w0, input logic [7:0] w1, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge t_clk);
            bus.i_valid = 1'b1;
            bus.i_sof   = (k == 0);
            bus.i_mode  = 2'b01;
            bus.i_bit   = {w1[k], w0[k]};
        end
    endtask

    task automatic chk_zero_out(input string name);
        chk(name, {bus.o_bit, bus.o_valid, bus.o_sof, bus.o_eof, bus.o_ovf, bus.o_frame_err}, 0);
    endtask

    initial begin
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] ea;
        logic [8:0] eb;

        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        in_word = 1'b0;
        nbeat   = 0;
        //             mode   in0    in1    ex0    ex1    ovf    stall gap
        tbl[0] = '{2'b01, 8'h05, 8'h80, 8'hFB, 8'h80, 2'b10, 1'b0, 1'b1};
        tbl[1] = '{2'b01, 8'h00, 8'h7F, 8'h00, 8'h81, 2'b00, 1'b0, 1'b0};
        tbl[2] = '{2'b10, 8'hFB, 8'h05, 8'h05, 8'h05, 2'b00, 1'b0, 1'b1};
        tbl[3] = '{2'b10, 8'h80, 8'h7F, 8'h80, 8'h7F, 2'b01, 1'b0, 1'b0};
        tbl[4] = '{2'b11, 8'h80, 8'h01, 8'h7F, 8'hFF, 2'b01, 1'b0, 1'b1};
        tbl[5] = '{2'b00, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 2'b00, 1'b1, 1'b1};
        tbl[6] = '{2'b11, 8'h01, 8'h00, 8'hFF, 8'h00, 2'b00, 1'b0, 1'b0};
        tbl[7] = '{2'b00, 8'h80, 8'hFF, 8'h80, 8'hFF, 2'b00, 1'b0, 1'b0};

        r           = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_mode  = 2'b00;
        bus.i_bit   = '0;
        repeat (3) @(negedge t_clk);
        chk_zero_out("reset_state");
        r = 1'b0;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].gap) idle(3);
            send_word(tbl[i].mode, tbl[i].in0, tbl[i].in1, tbl[i].ex0, tbl[i].ex1,
                      tbl[i].ovf, tbl[i].stall, 1'b0);
        end
        idle(12);

        // Random back-to-back words checked against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            m  = 2'($urandom_range(3, 0));
            a  = (i == 0) ? 8'h80 : 8'($urandom);
            b  = 8'($urandom);
            ea = model(m, a);
            eb = model(m, b);
            send_word(m, a, b, ea[7:0], eb[7:0], {eb[8], ea[8]}, 1'b0, 1'b0);
        end
        idle(12);

        // Framing: stray non-sof beat while idle, then sof re-asserted at bit 4
        @(negedge t_clk);
        bus.i_valid = 1'b1;
        bus.i_sof   = 1'b0;
        bus.i_bit   = 2'b11;
        fe_q.push_back(cyc + 1);
        idle(2);
        send_partial(8'h12, 8'h34, 4);
        send_word(2'b01, 8'h02, 8'h90, 8'hFE, 8'h70, 2'b00, 1'b0, 1'b1);
        idle(12);

        // Reset while a word is being emitted and the next is half collected
        send_word(2'b00, 8'h5A, 8'hC3, 8'h5A, 8'hC3, 2'b00, 1'b0, 1'b0);
        send_partial(8'hFF, 8'h80, 4);
        @(negedge t_clk);
        r           = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge t_clk);
        chk_zero_out("reset_mid_word");
        sb.delete();
        fe_q.delete();
        @(negedge t_clk);
        r = 1'b0;
        idle(12);
        send_word(2'b10, 8'hF0, 8'h10, 8'h10, 8'h10, 2'b00, 1'b0, 1'b0);
        idle(12);

        chk("sb_drain", sb.size(), 0);
        chk("frame_err_drain", fe_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
